// File: rtl/tcdm_wrr_mux_if.sv
// TCDM request/response bundle, NrPorts lanes wide. A single mux instance uses
// an NrPorts-wide bundle on its requester side and a one-lane bundle downstream.
interface tcdm_wrr_mux_if #(
  parameter int unsigned NrPorts   = 1,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned UserWidth = 1
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [NrPorts-1:0]                 q_valid;
  logic [NrPorts-1:0]                 q_ready;
  logic [NrPorts-1:0][AddrWidth-1:0]  q_addr;
  logic [NrPorts-1:0]                 q_write;
  logic [NrPorts-1:0][DataWidth-1:0]  q_data;
  logic [NrPorts-1:0][StrbWidth-1:0]  q_strb;
  logic [NrPorts-1:0][UserWidth-1:0]  q_user;
  logic [NrPorts-1:0]                 p_valid;
  logic [NrPorts-1:0][DataWidth-1:0]  p_data;

  modport master (
    output q_valid, q_addr, q_write, q_data, q_strb, q_user,
    input  q_ready, p_valid, p_data
  );

  modport slave (
    input  q_valid, q_addr, q_write, q_data, q_strb, q_user,
    output q_ready, p_valid, p_data
  );
endinterface

// File: rtl/tcdm_wrr_mux.sv
// Weighted round-robin TCDM multiplexer: per-port credits refilled once per epoch,
// a grant lock while the downstream stalls, and an index FIFO routing in-order responses.
module tcdm_wrr_mux #(
  parameter int unsigned NrPorts     = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned UserWidth   = 1,
  parameter int unsigned RespDepth   = 2,
  parameter int unsigned WeightWidth = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrPorts-1:0][WeightWidth-1:0] weight_i,
  tcdm_wrr_mux_if.slave                       slv,
  tcdm_wrr_mux_if.master                      mst
);

  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;

  logic [NrPorts-1:0][WeightWidth-1:0] credit_q;
  idx_t                                rr_q;
  logic                                lock_q;
  idx_t                                lock_idx_q;
  idx_t                                fifo_q [RespDepth];
  ptr_t                                wptr_q;
  ptr_t                                rptr_q;
  logic [CntW-1:0]                     count_q;

  logic [NrPorts-1:0] eligible;
  logic               sel_valid;
  idx_t               sel;
  logic               refill;
  logic               issue;
  logic               hs;
  logic               pop;
  idx_t               head;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (32'(p) == RespDepth - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NrPorts; i++) begin
      eligible[i] = slv.q_valid[i] && (credit_q[i] != '0);
    end
  end

  // A locked grant wins outright; otherwise scan forward from rr with wrap.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel       = '0;
    sel_valid = 1'b0;
    if (lock_q) begin
      sel       = lock_idx_q;
      sel_valid = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NrPorts; k++) begin
        cand = (32'(rr_q) + k) % NrPorts;
        if (!sel_valid && eligible[idx_t'(cand)]) begin
          sel       = idx_t'(cand);
          sel_valid = 1'b1;
        end
      end
    end
  end

  assign refill = !rst_i && (|slv.q_valid) && !sel_valid;
  assign issue  = !rst_i && sel_valid && (count_q < CntW'(RespDepth));
  assign hs     = issue && mst.q_ready[0];
  assign pop    = !rst_i && mst.p_valid[0] && (count_q != '0);
  assign head   = fifo_q[rptr_q];

  assign mst.q_valid[0] = issue;
  assign mst.q_addr[0]  = slv.q_addr[sel];
  assign mst.q_write[0] = slv.q_write[sel];
  assign mst.q_data[0]  = slv.q_data[sel];
  assign mst.q_strb[0]  = slv.q_strb[sel];
  assign mst.q_user[0]  = slv.q_user[sel];

  always_comb begin
    slv.q_ready      = '0;
    slv.q_ready[sel] = hs;
    slv.p_valid      = '0;
    slv.p_valid[head] = pop;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      slv.p_data[i] = mst.p_data[0];
    end
  end

  // Control state: credits, pointer, lock and FIFO occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q   <= '0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      if (refill) begin
        for (int unsigned i = 0; i < NrPorts; i++) begin
          credit_q[i] <= (weight_i[i] == '0) ? WeightWidth'(1) : weight_i[i];
        end
      end else if (hs) begin
        credit_q[sel] <= credit_q[sel] - WeightWidth'(1);
      end
      if (hs) begin
        rr_q   <= (32'(sel) == NrPorts - 1) ? '0 : sel + 1'b1;
        lock_q <= 1'b0;
      end else if (issue) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (hs)  wptr_q <= ptr_inc(wptr_q);
      if (pop) rptr_q <= ptr_inc(rptr_q);
      case ({hs, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO payload needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (hs) fifo_q[wptr_q] <= sel;
  end

  always @(posedge clk_i) begin
    if (!rst_i && lock_q) begin
      assert (slv.q_valid[lock_idx_q])
        else $error("tcdm_wrr_mux: locked requester %0d dropped valid", lock_idx_q);
    end
    if (!rst_i) begin
      assert (!(mst.p_valid[0] && count_q == '0))
        else $warning("tcdm_wrr_mux: response with nothing outstanding dropped");
    end
  end

endmodule
